// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared FSM state type and ALUControl encodings for the execute stage
package mul_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} mul_state_t;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add MUL on the shared ALU (ports: clk/reset, start+opA_E/opB_E in, ALU a/b/control/own + aluResult_i, stall_o, done_o, product_o)
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] opA_E,
  input  logic [N-1:0] opB_E,
  input  logic [N-1:0] aluResult_i,
  output logic [N-1:0] aluA_o,
  output logic [N-1:0] aluB_o,
  output logic [3:0]   aluControl_o,
  output logic         aluOwn_o,
  output logic         stall_o,
  output logic         done_o,
  output logic [N-1:0] product_o
);
  mul_state_t   state_q;
  logic [N-1:0] acc_q, mcand_q, mplier_q, product_q, acc_d;
  logic         done_q;
  assign acc_d = mplier_q[0] ? aluResult_i : acc_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            acc_q    <= '0;
            mcand_q  <= opA_E;
            mplier_q <= opB_E;
            state_q  <= ITER;
          end
        end
        ITER: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (mplier_q[N-1:1] == '0) begin
            product_q <= acc_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign aluA_o       = acc_q;
  assign aluB_o       = mcand_q;
  assign aluControl_o = ALU_ADD;
  assign aluOwn_o     = state_q == ITER;
  assign stall_o      = (state_q == ITER) | ((state_q == IDLE) & start);
  assign done_o       = done_q;
  assign product_o    = product_q;
endmodule
